// File: rtl/pyramid_pkg.sv
// Shared definitions for the pyramid level schedulers and the downstream level demux.
package pyramid_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int BURST_LEN_DEF = 8;

    // Level tag width; a single level still needs a 1-bit tag.
    function automatic int lvl_w(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

endpackage

// File: rtl/pyramid_stream_arbiter_rr_priority_pick.sv
// Round-robin find-first-set over req starting at ptr, wrapping modulo N.
// Combinational, zero latency; no flow control of its own.
// Stateless: the caller owns the pointer and decides when to advance it.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    logic         hi_found;

    // Descending scan leaves the lowest set index at/above ptr in hi_idx and
    // the lowest set index overall in lo_idx (the wrapped winner).
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = W'(j);
                if (W'(j) >= ptr) begin
                    hi_idx   = W'(j);
                    hi_found = 1'b1;
                end
            end
        end
        idx   = hi_found ? hi_idx : lo_idx;
        found = |req;
    end

endmodule

// File: rtl/pyramid_stream_arbiter.sv
// Round-robin burst arbiter merging pyramid level streams into one tagged stream.
// Latency: 1 cycle arbitration (IDLE) before in_ready, 1 cycle input-to-output register.
// Backpressure: in_ready drops combinationally while the output register is full and stalled.
module pyramid_stream_arbiter
    import pyramid_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEVELS     = 15,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int LVL_W      = lvl_w(LEVELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LEVELS-1:0]            level_enable,
    input  logic [LEVELS-1:0]            in_valid,
    input  logic [DATA_WIDTH*LEVELS-1:0] in_pixels,
    output logic [LEVELS-1:0]            in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_pixel,
    output logic [LVL_W-1:0]             out_level,
    output logic                         out_last,
    output logic                         busy
);

    localparam int               CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [LVL_W-1:0] TOP_LVL  = LVL_W'(LEVELS - 1);

    arb_state_t       state;
    logic [LVL_W-1:0] g;
    logic [LVL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [LEVELS-1:0] req;
    logic [LVL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              g_en;
    logic              g_vld;
    logic              out_free;
    logic              xfer;
    logic [LVL_W-1:0]  g_next;

    assign req = in_valid & level_enable;

    rr_priority_pick #(
        .N (LEVELS),
        .W (LVL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign g_en     = level_enable[g];
    assign g_vld    = in_valid[g];
    assign out_free = !out_valid || out_ready;
    assign xfer     = (state == ST_BURST) && g_en && g_vld && out_free;
    assign g_next   = (g == TOP_LVL) ? '0 : g + 1'b1;
    assign busy     = (state == ST_BURST);

    always_comb begin
        in_ready = '0;
        if (state == ST_BURST && g_en && out_free) begin
            in_ready[g] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            g         <= '0;
            ptr       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_level <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        g     <= pick_idx;
                        cnt   <= '0;
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (xfer) begin
                        if (cnt == LAST_CNT) begin
                            cnt   <= '0;
                            ptr   <= g_next;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (!g_vld || !g_en) begin
                        // Truncated burst: hand the turn on without an out_last.
                        ptr   <= g_next;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (xfer) begin
                out_valid <= 1'b1;
                out_pixel <= in_pixels[g*DATA_WIDTH +: DATA_WIDTH];
                out_level <= g;
                out_last  <= (cnt == LAST_CNT);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pyramid_stream_arbiter.sv
// Scoreboard bench for pyramid_stream_arbiter with 4 levels and 4-beat bursts.
module tb_pyramid_stream_arbiter;

    localparam int DW = 8;
    localparam int LV = 4;
    localparam int BL = 4;
    localparam int LW = 2;

    typedef struct {
        logic [LW-1:0] lvl;
        logic [DW-1:0] pix;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [LV-1:0]     level_enable;
    logic [LV-1:0]     in_valid;
    logic [DW*LV-1:0]  in_pixels;
    logic [LV-1:0]     in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_pixel;
    logic [LW-1:0]     out_level;
    logic              out_last;
    logic              busy;

    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       src_left[LV];
    int       src_seq[LV];
    logic [DW-1:0] src_base[LV];
    bit       bp_mode;
    beat_t    exp_q[$];
    int       hs_cyc[$];

    always #5 clk = ~clk;

    pyramid_stream_arbiter #(
        .DATA_WIDTH (DW),
        .LEVELS     (LV),
        .BURST_LEN  (BL),
        .LVL_W      (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .level_enable (level_enable),
        .in_valid     (in_valid),
        .in_pixels    (in_pixels),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_level    (out_level),
        .out_last     (out_last),
        .busy         (busy)
    );

    task automatic drive_inputs();
        for (int i = 0; i < LV; i++) begin
            in_valid[i]            = (src_left[i] > 0);
            in_pixels[i*DW +: DW]  = src_base[i] + DW'(src_seq[i]);
        end
    endtask

    task automatic push_burst(input int l, input int s0, input int n);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.lvl  = LW'(l);
            e.pix  = src_base[l] + DW'(s0 + b);
            e.last = (b == BL - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: settle inputs, check, consume the edge, advance the sources.
    task automatic tick();
        logic [LV-1:0] hs;
        beat_t         e;
        if (bp_mode) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        else         out_ready = 1'b1;
        drive_inputs();
        #1;
        total++;
        if ((in_ready & ~level_enable) != 0 || $countones(in_ready) > 1) begin
            bad++;
            $display("FAIL in_ready_legal: in_ready=%b mask=%b", in_ready, level_enable);
        end
        if (out_valid && !out_ready) begin
            total++;
            if (in_ready !== '0) begin
                bad++;
                $display("FAIL in_ready_hold: in_ready=%b while output stalled, need 0000", in_ready);
            end
        end
        hs = in_valid & in_ready;
        if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: lvl=%0d pix=%h last=%b", out_level, out_pixel, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_level, out_pixel, out_last} !== {e.lvl, e.pix, e.last}) begin
                    bad++;
                    $display("FAIL beat: got lvl=%0d pix=%h last=%b, need lvl=%0d pix=%h last=%b",
                             out_level, out_pixel, out_last, e.lvl, e.pix, e.last);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < LV; i++) begin
            if (hs[i]) begin
                src_left[i]--;
                src_seq[i]++;
            end
        end
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, need 0", exp_q.size());
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < LV; i++) begin
            src_left[i] = 0;
            src_seq[i]  = 0;
            src_base[i] = DW'(i * 64);
        end
        exp_q.delete();
        hs_cyc.delete();
        drive_inputs();
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        out_ready    = 1'b1;
        bp_mode      = 1'b0;
        level_enable = 4'hF;
        clear_sources();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        out_ready    = 1'b1;
        bp_mode      = 1'b0;
        level_enable = 4'hF;
        clear_sources();
        #2;
        total++;
        if ({out_valid, out_pixel, out_level, out_last, busy, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_state: v=%b pix=%h lvl=%0d last=%b busy=%b rdy=%b, need all 0",
                     out_valid, out_pixel, out_level, out_last, busy, in_ready);
        end
        do_reset();
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: busy=%b out_valid=%b, need 0 0", busy, out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < LV; i++) src_left[i] = 8;
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < LV; l++) push_burst(l, r * 4, 4);
        run_until_empty(200);
        total++;
        if (hs_cyc.size() == 0 || hs_cyc[0] != 2) begin
            bad++;
            $display("FAIL first_beat_latency: got cycle %0d, need 2",
                     (hs_cyc.size() == 0) ? -1 : hs_cyc[0]);
        end
        for (int k = 1; k < hs_cyc.size(); k++) begin
            total++;
            if (hs_cyc[k] - hs_cyc[k-1] != ((k % BL == 0) ? 2 : 1)) begin
                bad++;
                $display("FAIL rr_gap: beat %0d gap=%0d, need %0d", k,
                         hs_cyc[k] - hs_cyc[k-1], (k % BL == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_masking();
        do_reset();
        level_enable = 4'b1010;
        for (int i = 0; i < LV; i++) src_left[i] = 8;
        push_burst(1, 0, 4);
        push_burst(3, 0, 4);
        push_burst(1, 4, 4);
        push_burst(3, 4, 4);
        run_until_empty(200);
    endtask

    task automatic test_backpressure();
        do_reset();
        src_base[2] = 8'h10;
        src_left[2] = 4;
        bp_mode     = 1'b1;
        push_burst(2, 0, 4);
        run_until_empty(100);
        bp_mode = 1'b0;
    endtask

    task automatic test_early_release();
        do_reset();
        src_left[1] = 2;
        src_left[3] = 4;
        push_burst(1, 0, 2);
        push_burst(3, 0, 4);
        run_until_empty(100);
        total++;
        if (hs_cyc.size() < 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
            bad++;
            $display("FAIL release_gap: got %0d, need 3",
                     (hs_cyc.size() < 3) ? -1 : hs_cyc[2] - hs_cyc[1]);
        end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        src_left[3] = 4;
        push_burst(3, 0, 4);
        run_until_empty(100);
        src_left[0] = 4;
        src_left[3] = 4;
        push_burst(0, 0, 4);
        push_burst(3, 4, 4);
        run_until_empty(100);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        src_left[1] = 4;
        src_left[2] = 4;
        push_burst(1, 0, 4);
        push_burst(2, 0, 2);
        run_until_empty(100);
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== '0) begin
            bad++;
            $display("FAIL reset_mid_burst: out_valid=%b busy=%b in_ready=%b, need 0 0 0000",
                     out_valid, busy, in_ready);
        end
        clear_sources();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        src_left[0] = 4;
        src_left[2] = 4;
        push_burst(0, 0, 4);
        push_burst(2, 0, 4);
        run_until_empty(100);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_masking();
        test_backpressure();
        test_early_release();
        test_pointer_wrap();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pyramid_stream_arbiter.md
# pyramid_stream_arbiter

Round-robin scheduler that merges the per-level pixel streams of `gaussian_pyramid` into one valid/ready stream for the downstream HOG feature pipeline. Each grant is held for a burst of up to `BURST_LEN` pixels, and every output beat is tagged with its source level. A per-level enable mask lets software choose which pyramid scales are processed. The output is a one-entry register stage.

## Interface
- `DATA_WIDTH`, 8: pixel width.
- `LEVELS`, 15: number of pyramid levels (requesters).
- `BURST_LEN`, 8: maximum beats per grant; legal range 1..256.
- `LVL_W`, `$clog2(LEVELS)` (minimum 1): level tag width.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `level_enable`  in  LEVELS  per-level enable mask; a level whose bit is 0 is never granted.
- `in_valid`  in  LEVELS  per-level valid.
- `in_pixels`  in  DATA_WIDTH*LEVELS  level i pixel on `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`  out  LEVELS  per-level ready; at most one bit high (onehot0).
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream ready.
- `out_pixel`  out  DATA_WIDTH  registered pixel.
- `out_level`  out  LVL_W  source level of `out_pixel`.
- `out_last`  out  1  beat completes a full `BURST_LEN` burst.
- `busy`  out  1  high while in BURST.

## Operation
- FSM states:
  - IDLE: arbitrating; no grant.
  - BURST: grant held on level `g`.
- IDLE:
  - Request vector: `req = in_valid & level_enable`.
  - Scan from pointer `ptr` upward, modulo LEVELS; the first set bit wins.
  - On a win, register `g`, clear beat counter `cnt`, and go to BURST.
  - If `req == 0`, stay in IDLE.
  - `in_ready` is all zeros in IDLE.
- BURST:
  - `in_ready[g] = level_enable[g] && (!out_valid || out_ready)`; all other bits are 0.
  - Transfer on `in_valid[g] && in_ready[g]`:
    - Output register loads `in_pixels[g]`, `out_level <= g`, and `out_valid <= 1`.
    - `out_last <= (cnt == BURST_LEN-1)`.
    - `cnt <= cnt + 1`.
  - Burst end (last beat transferred):
    - `ptr <= (g == LEVELS-1) ? 0 : g+1`.
    - Next state is IDLE.
  - Early release: if `in_valid[g] == 0` or `level_enable[g] == 0` in BURST with no transfer, go to IDLE.
    - `ptr <= g+1` (same wrap rule).
    - No `out_last` is issued for the truncated burst.
- Output register:
  - With no new transfer, `out_valid` clears when `out_ready` is high.
  - All output fields hold while `out_valid && !out_ready`.
- `cnt` width is `$clog2(BURST_LEN+1)`. It never exceeds `BURST_LEN-1` before reset to 0.
- `busy` = (state == BURST).

## Timing
- Reset values (async assert, released synchronously to `clk`):
  - state IDLE, `ptr = 0`, `cnt = 0`, `g = 0`.
  - `out_valid = 0`, `out_pixel = 0`, `out_level = 0`, `out_last = 0`.
  - `busy = 0`, `in_ready = 0`.
- Arbitration latency: 1 cycle from request in IDLE to `in_ready[g]` high.
- Data latency: 1 cycle from input transfer to `out_valid`.
- Throughput:
  - One beat per cycle within a burst while `out_ready` is high.
  - One bubble cycle (IDLE) between bursts.
  - Full-length bursts therefore sustain `BURST_LEN/(BURST_LEN+1)`.
- Backpressure: `out_ready` low with `out_valid` high drops `in_ready[g]` combinationally in the same cycle. No beat is lost or duplicated.
- Last beat with output full: the final beat is accepted only when `!out_valid || out_ready`. State leaves BURST on the cycle after acceptance.
- Mid-burst mask change: a transfer already qualified in the cycle completes. Release occurs on the next cycle.
- Reset mid-burst: all state is cleared immediately. The pending output beat is discarded.
- `BURST_LEN == 1`: every beat has `out_last = 1`, and the FSM returns to IDLE after each beat.
- `LEVELS == 1`: `LVL_W = 1`, and `ptr` stays 0.

## Structure
- Shared package `pyramid_pkg`:
  - FSM state encoding.
  - The `LVL_W` computation function.
  - `BURST_LEN` default constant, shared with downstream level demux logic.
- One natural sub-module: `rr_priority_pick`. It is a combinational round-robin find-first-set from `ptr` over `req`, returning index and found flag. It is reused by later per-level schedulers.
- The FSM, counter, and output register live in `pyramid_stream_arbiter`.

## Test plan
Bench configuration: `LEVELS=4`, `BURST_LEN=4`, `DATA_WIDTH=8`.

- **Round-robin:** all four levels valid continuously, mask `4'hF`, `out_ready=1`.
  - Expect `out_level` sequence 0,0,0,0,1,1,1,1,2…,3…,0 with one bubble between bursts.
  - `out_last` high on every 4th beat.
- **Masking:** mask `4'b1010`, all levels valid.
  - Expect only levels 1 and 3, alternating in bursts of 4.
  - `in_ready[0]` and `in_ready[2]` never high.
- **Backpressure:** level 2 only, pixels 0x10..0x13; `out_ready` toggles 1,0,0,1,….
  - Expect output 0x10,0x11,0x12,0x13 in order with no loss or duplication.
  - `in_ready[2]` is low whenever the output is held.
- **Early release:** level 1 valid for 2 beats then drops; level 3 valid.
  - Expect 2 beats from level 1 with `out_last=0`, then IDLE, then a full burst from level 3.
- **Pointer wrap:** only level 3 valid; after its burst, levels 0 and 3 both valid.
  - Expect level 0 granted next (`ptr` wrapped to 0).
- **Reset mid-burst:** assert `rst=0` after the 2nd beat.
  - Expect `out_valid=0`, `busy=0`, and `in_ready=0` immediately.
  - After release, arbitration restarts at level 0.
